i2c_slave: RTL and testbench

I2C target (responder) that sits on the same two-wire bus as the team's I2C master and answers a single 7-bit address. It oversamples SCL/SDA with the system clock, detects START/STOP, and ACKs its address. Write bytes are delivered on a byte-wide output with a valid strobe. For reads it serves bytes from a byte-wide input. SDA is open-drain: the block only ever pulls low.

---
 rtl/i2c_slave.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target answering a single 7-bit address.
// SCL/SDA are oversampled with clk; START/STOP are detected in any state.
// Write bytes are presented on rx_data with a one-clk rx_valid strobe and always ACKed.
// Read bytes are latched from tx_data in the clk tx_req is raised for.
// SDA is open-drain: sda_oe = 1 pulls the line low, 0 releases it.
// Ports:
//   clk      system clock (SCL high/low phases each >= 4 clk)
//   reset    asynchronous active-low reset
//   scl_in   bus SCL level, asynchronous
//   sda_in   bus SDA level, asynchronous
//   sda_oe   1 = pull SDA low
//   rx_data  last byte received in a write transfer
//   rx_valid one-clk pulse when rx_data is updated
//   tx_data  byte returned in a read transfer
//   tx_req   one-clk pulse, raised for the clk in which tx_data was latched
//   busy     1 from address match until STOP/START/NACK
module i2c_slave #(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StAddr     = 3'd1;
  localparam logic [2:0] StAckAddr  = 3'd2;
  localparam logic [2:0] StWrite    = 3'd3;
  localparam logic [2:0] StAckWrite = 3'd4;
  localparam logic [2:0] StRead     = 3'd5;
  localparam logic [2:0] StReadAck  = 3'd6;
  localparam logic [2:0] StWaitStop = 3'd7;

  // [0],[1] synchronizer, [2] history
  logic [2:0] scl_q, sda_q;
  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic       oe_q, oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign sda_s     = sda_q[1];
  assign scl_rise  = scl_s & ~scl_q[2];
  assign scl_fall  = ~scl_s & scl_q[2];
  assign start_det = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
  assign stop_det  = scl_s & scl_q[2] & ~sda_q[2] & sda_s;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    oe_d       = oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == ADDRESS) begin
              oe_d    = 1'b1;
              busy_d  = 1'b1;
              rw_d    = shift_q[0];
              state_d = StAckAddr;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        StAckAddr: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (!rw_q) begin
              oe_d    = 1'b0;
              state_d = StWrite;
            end else begin
              tx_req_d = 1'b1;
              shift_d  = tx_data;
              oe_d     = ~tx_data[7];
              state_d  = StRead;
            end
          end
        end
        StWrite: begin
          // cnt 8 = byte complete but not yet delivered, 9 = delivered, awaiting ACK slot
          if (cnt_q == 4'd8) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            cnt_d      = 4'd9;
          end else if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd9) begin
            oe_d    = 1'b1;
            state_d = StAckWrite;
          end
        end
        StAckWrite: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = StWrite;
          end
        end
        StRead: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q != 4'd0) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = StReadAck;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        StReadAck: begin
          if (scl_rise && cnt_q == 4'd8) begin
            if (sda_s) begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
              oe_d    = 1'b0;
            end else begin
              cnt_d = 4'd9;
            end
          end else if (scl_fall && cnt_q == 4'd9) begin
            tx_req_d = 1'b1;
            shift_d  = tx_data;
            oe_d     = ~tx_data[7];
            cnt_d    = 4'd0;
            state_d  = StRead;
          end
        end
        StWaitStop: oe_d = 1'b0;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      cnt_q      <= 4'd0;
      oe_q       <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_in};
      sda_q      <= {sda_q[1:0], sda_in};
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      oe_q       <= oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign sda_oe   = oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;

  localparam int T = 40;  // quarter SCL period (4 clk)

  logic       clk;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;

  logic [7:0] tx_tab [16];
  int         rx_cnt;
  int         tx_cnt;
  int         overlap;
  int         errors;
  int         checks;

  assign sda_bus = sda_m & ~sda_oe;
  assign tx_data = tx_tab[tx_cnt[3:0]];

  i2c_slave #(.ADDRESS(7'h50)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors; tx_cnt also selects the next byte to offer on tx_data.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      overlap <= overlap;
    end else begin
      if (rx_valid) rx_cnt <= rx_cnt + 1;
      if (tx_req) tx_cnt <= tx_cnt + 1;
      if (rx_valid && tx_req) overlap <= overlap + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #T;
    scl = 1'b1; #T;
    sda_m = 1'b0; #T;
    scl = 1'b0; #T;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #T;
    scl = 1'b1; #T;
    sda_m = 1'b1; #T;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #T;
    scl = 1'b1; #(2*T);
    scl = 1'b0; #T;
  endtask

  // ack = 1 when the target pulled SDA low during the ninth clock
  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #T;
    scl = 1'b1; #T;
    ack = ~sda_bus; #T;
    scl = 1'b0; #T;
  endtask

  task automatic read_byte(input logic m_ack, output logic [7:0] b, output logic oe9);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #T;
      scl = 1'b1; #T;
      b[i] = sda_bus; #T;
      scl = 1'b0; #T;
    end
    sda_m = ~m_ack; #T;
    scl = 1'b1; #T;
    oe9 = sda_oe; #T;
    scl = 1'b0; #T;
  endtask

  initial begin
    logic       ack;
    logic       oe9;
    logic [7:0] b;
    int         rx0;
    int         tx0;
    errors  = 0;
    checks  = 0;
    rx_cnt  = 0;
    tx_cnt  = 0;
    overlap = 0;
    for (int i = 0; i < 16; i++) tx_tab[i] = 8'h00;
    scl   = 1'b1;
    sda_m = 1'b1;
    reset = 1'b0;
    #23;
    check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_tx_req", {31'd0, tx_req}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    #50;

    // Write 0x50 / 0xAA
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", {31'd0, ack}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    write_byte(8'hAA, ack);
    check("wr_data_ack", {31'd0, ack}, 32'd1);
    check("wr_rx_data", {24'd0, rx_data}, 32'hAA);
    check("wr_rx_pulses", rx_cnt - rx0, 32'd1);
    i2c_stop();
    #50;
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Wrong address 0x51
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    check("bad_addr_ack", {31'd0, ack}, 32'd0);
    check("bad_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h12, ack);
    check("bad_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    #50;
    check("bad_rx_pulses", rx_cnt - rx0, 32'd0);

    // Read two bytes: ACK then NACK
    tx0 = tx_cnt;
    tx_tab[(tx_cnt) % 16] = 8'h3C;
    tx_tab[(tx_cnt + 1) % 16] = 8'hC5;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", {31'd0, ack}, 32'd1);
    read_byte(1'b1, b, oe9);
    check("rd_byte1", {24'd0, b}, 32'h3C);
    check("rd_oe9_1", {31'd0, oe9}, 32'd0);
    read_byte(1'b0, b, oe9);
    check("rd_byte2", {24'd0, b}, 32'hC5);
    check("rd_oe9_2", {31'd0, oe9}, 32'd0);
    check("rd_busy_after_nack", {31'd0, busy}, 32'd0);
    i2c_stop();
    #50;
    check("rd_tx_pulses", tx_cnt - tx0, 32'd2);

    // Write 0x01, repeated START, read 0x77
    tx_tab[(tx_cnt) % 16] = 8'h77;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h01, ack);
    check("rs_wr_ack", {31'd0, ack}, 32'd1);
    check("rs_rx_data", {24'd0, rx_data}, 32'h01);
    i2c_start();
    write_byte(8'hA1, ack);
    check("rs_rd_addr_ack", {31'd0, ack}, 32'd1);
    read_byte(1'b0, b, oe9);
    check("rs_rd_byte", {24'd0, b}, 32'h77);
    i2c_stop();
    #50;

    // Aborted byte, then a full write
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i2c_stop();
    #50;
    check("abort_rx_pulses", rx_cnt - rx0, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h5A, ack);
    i2c_stop();
    #50;
    check("after_abort_rx_data", {24'd0, rx_data}, 32'h5A);
    check("after_abort_rx_pulses", rx_cnt - rx0, 32'd1);

    // Reset during data ACK
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'b0);
    sda_m = 1'b1; #T;
    scl = 1'b1; #T;
    check("rst_ack_driven", {31'd0, sda_oe}, 32'd1);
    reset = 1'b0;
    #2;
    check("rst_async_release", {31'd0, sda_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    #20;
    reset = 1'b1;
    #T;
    scl = 1'b0; #T;
    rx0 = rx_cnt;
    write_byte(8'hA0, ack);
    check("rst_no_resume_ack", {31'd0, ack}, 32'd0);
    check("rst_no_resume_busy", {31'd0, busy}, 32'd0);
    check("rst_no_resume_rx", rx_cnt - rx0, 32'd0);
    i2c_start();
    write_byte(8'hA0, ack);
    check("rst_new_start_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    #50;
    check("final_busy", {31'd0, busy}, 32'd0);
    check("no_rx_tx_overlap", overlap, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
